// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer.
//   - ALU operation codes driven on alu_operation
//   - R-type funct codes recognised by the decoder
//   - ALUOp encodings coming from the main control unit
//   - FSM state encoding for the sequencer
package alu_ctrl_pkg;

    // ALU operation codes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    // R-type funct codes
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    // ALUOp encodings from the main control unit
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU operation decoder.
// Ports:
//   aluop        in   2        ALUOp from main control
//   funct        in   FUNCT_W  R-type funct field (only meaningful for ALUOp=10)
//   operation    out  OP_W     ALU operation code (OP_AND when illegal)
//   illegal      out  1        unsupported ALUOp / funct combination
//   signed_arith out  1        signed add/sub (funct 0x20 / 0x22), eligible for overflow trap
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int OP_W    = 4
) (
    input  logic [1:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [OP_W-1:0]    operation,
    output logic               illegal,
    output logic               signed_arith
);

    always_comb begin
        operation    = OP_W'(OP_AND);
        illegal      = 1'b0;
        signed_arith = 1'b0;
        case (aluop)
            ALUOP_ADD: operation = OP_W'(OP_ADD);
            ALUOP_SUB: operation = OP_W'(OP_SUB);
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_W'(F_ADD): begin
                        operation    = OP_W'(OP_ADD);
                        signed_arith = 1'b1;
                    end
                    FUNCT_W'(F_ADDU): operation = OP_W'(OP_ADD);
                    FUNCT_W'(F_SUB): begin
                        operation    = OP_W'(OP_SUB);
                        signed_arith = 1'b1;
                    end
                    FUNCT_W'(F_SUBU): operation = OP_W'(OP_SUB);
                    FUNCT_W'(F_AND):  operation = OP_W'(OP_AND);
                    FUNCT_W'(F_OR):   operation = OP_W'(OP_OR);
                    FUNCT_W'(F_NOR):  operation = OP_W'(OP_NOR);
                    FUNCT_W'(F_SLT):  operation = OP_W'(OP_SLT);
                    default:          illegal   = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequenced issuer for the datapath ALU.
// Accepts (ALUOp, funct, A, B) over valid/ready, registers operands and the decoded
// op code onto the ALU inputs, waits one cycle for the ALU to settle, and captures
// result and flags into a response held until the consumer accepts it.
// FSM: IDLE -> EXEC -> RESP -> IDLE (illegal requests skip EXEC).
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_valid/req_ready                request handshake (ready only in IDLE)
//   req_aluop, req_funct, req_a, req_b request payload
//   alu_a, alu_b, alu_operation        registered ALU inputs
//   alu_result, alu_zero, alu_carry,
//   alu_overflow                       ALU outputs
//   rsp_valid/rsp_ready                response handshake
//   rsp_result, rsp_zero, rsp_carry,
//   rsp_illegal, rsp_trap              captured response payload
// Build option: define ALU_CTRL_TRAP_EN to trap signed add/sub overflow
// (rsp_trap=1, rsp_result forced to 0). Without it rsp_trap stays 0.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 6,
    parameter int OP_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_aluop,
    input  logic [FUNCT_W-1:0] req_funct,
    input  logic [DATA_W-1:0]  req_a,
    input  logic [DATA_W-1:0]  req_b,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_operation,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_overflow,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_zero,
    output logic               rsp_carry,
    output logic               rsp_illegal,
    output logic               rsp_trap
);

    state_e              state, state_nxt;
    logic                accept;
    logic [OP_W-1:0]     dec_op;
    logic                dec_illegal;
    logic                dec_signed;
    logic                signed_p1;
    logic                trap_hit;

    // A trapped signed add/sub reports zero instead of the wrapped result.
    function automatic logic [DATA_W-1:0] trap_result(input logic [DATA_W-1:0] res,
                                                      input logic              trap);
        return trap ? '0 : res;
    endfunction

    alu_ctrl_decode #(
        .FUNCT_W (FUNCT_W),
        .OP_W    (OP_W)
    ) u_decode (
        .aluop        (req_aluop),
        .funct        (req_funct),
        .operation    (dec_op),
        .illegal      (dec_illegal),
        .signed_arith (dec_signed)
    );

    assign accept = req_valid && req_ready;

`ifdef ALU_CTRL_TRAP_EN
    assign trap_hit = signed_p1 && alu_overflow;
`else
    assign trap_hit = 1'b0;
    logic unused_trap;
    assign unused_trap = signed_p1 ^ alu_overflow;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = dec_illegal ? ST_RESP : ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
    end

    // Stage p0 -> p1: issue operands/op to the ALU on accept
    // Stage p1 -> p2: capture ALU outputs into the response at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_operation <= '0;
            signed_p1     <= 1'b0;
            rsp_result    <= '0;
            rsp_zero      <= 1'b0;
            rsp_carry     <= 1'b0;
            rsp_illegal   <= 1'b0;
            rsp_trap      <= 1'b0;
        end else if (accept) begin
            alu_a         <= req_a;
            alu_b         <= req_b;
            alu_operation <= dec_op;
            signed_p1     <= dec_signed;
            // Illegal requests bypass EXEC, so their response is built here.
            if (dec_illegal) begin
                rsp_result  <= '0;
                rsp_zero    <= 1'b0;
                rsp_carry   <= 1'b0;
                rsp_illegal <= 1'b1;
                rsp_trap    <= 1'b0;
            end
        end else if (state == ST_EXEC) begin
            rsp_result  <= trap_result(alu_result, trap_hit);
            rsp_zero    <= alu_zero;
            rsp_carry   <= alu_carry;
            rsp_illegal <= 1'b0;
            rsp_trap    <= trap_hit;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with a behavioural ALU attached to the alu_* ports.
module tb_alu_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_aluop;
    logic [5:0]  req_funct;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_operation;
    logic [31:0] alu_result;
    logic        alu_zero, alu_carry, alu_overflow;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_carry, rsp_illegal, rsp_trap;
    logic        force_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(.DATA_W(32), .FUNCT_W(6), .OP_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_aluop     (req_aluop),
        .req_funct     (req_funct),
        .req_a         (req_a),
        .req_b         (req_b),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_carry     (alu_carry),
        .alu_overflow  (alu_overflow),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_zero      (rsp_zero),
        .rsp_carry     (rsp_carry),
        .rsp_illegal   (rsp_illegal),
        .rsp_trap      (rsp_trap)
    );

    // Behavioural ALU; force_ovf lets the bench inject an overflow flag.
    logic [32:0] sum;
    always_comb begin
        sum          = 33'd0;
        alu_result   = 32'd0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_operation)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = sum[31:0];
                alu_carry    = sum[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            4'b0110: begin
                sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result   = sum[31:0];
                alu_carry    = sum[32];
                alu_overflow = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
            end
            4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'd0;
        endcase
        alu_overflow = alu_overflow | force_ovf;
        alu_zero     = (alu_result == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_op(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [5:0]  b2b_funct [4] = '{6'h24, 6'h25, 6'h27, 6'h2A};
    logic [3:0]  b2b_op    [4] = '{4'b0000, 4'b0001, 4'b1100, 4'b0111};
    // a=F0F000FF b=0FF00F0F: AND, OR, NOR, SLT (a negative < b positive)
    logic [31:0] b2b_res   [4] = '{32'h00F0000F, 32'hFFF00FFF, 32'h000FF000, 32'h00000001};

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_aluop = 2'b00;
        req_funct = 6'h00;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b0;
        force_ovf = 1'b0;
        tick();
        tick();

        // Reset state
        chk_b("rst_req_ready", req_ready, 1'b1);
        chk_b("rst_rsp_valid", rsp_valid, 1'b0);
        chk_w("rst_alu_a", alu_a, 32'd0);
        chk_op("rst_alu_op", alu_operation, 4'b0000);
        chk_w("rst_rsp_result", rsp_result, 32'd0);
        chk_b("rst_rsp_illegal", rsp_illegal, 1'b0);
        rst_n = 1'b1;
        tick();

        // R-type add 5 + 7
        req_valid = 1'b1; req_aluop = 2'b10; req_funct = 6'h20; req_a = 32'd5; req_b = 32'd7;
        tick();
        req_valid = 1'b0;
        chk_op("add_op", alu_operation, 4'b0010);
        chk_w("add_alu_a", alu_a, 32'd5);
        chk_w("add_alu_b", alu_b, 32'd7);
        chk_b("add_valid_e1", rsp_valid, 1'b0);
        chk_b("add_ready_e1", req_ready, 1'b0);
        tick();
        chk_b("add_valid_e2", rsp_valid, 1'b1);
        chk_w("add_result", rsp_result, 32'd12);
        chk_b("add_zero", rsp_zero, 1'b0);
        chk_b("add_illegal", rsp_illegal, 1'b0);
        chk_b("add_trap", rsp_trap, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_b("add_retired", rsp_valid, 1'b0);
        chk_b("add_idle_ready", req_ready, 1'b1);
        chk_w("add_payload_hold", rsp_result, 32'd12);

        // Branch subtract, equal operands, with a stalled consumer
        req_valid = 1'b1; req_aluop = 2'b01; req_funct = 6'h00; req_a = 32'h1234; req_b = 32'h1234;
        tick();
        chk_op("beq_op", alu_operation, 4'b0110);
        // Keep a different request pending to prove it is not taken while busy
        req_aluop = 2'b00; req_a = 32'hDEAD; req_b = 32'h1;
        tick();
        chk_b("beq_valid", rsp_valid, 1'b1);
        chk_b("beq_zero", rsp_zero, 1'b1);
        chk_w("beq_result", rsp_result, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_b("stall_valid", rsp_valid, 1'b1);
            chk_b("stall_zero", rsp_zero, 1'b1);
            chk_b("stall_req_ready", req_ready, 1'b0);
            chk_w("stall_alu_a", alu_a, 32'h1234);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_b("beq_retired", rsp_valid, 1'b0);
        chk_b("beq_idle_ready", req_ready, 1'b1);
        chk_w("no_accept_on_retire", alu_a, 32'h1234);
        req_valid = 1'b0;

        // Signed sub 1 - 2 with injected overflow
        force_ovf = 1'b1;
        req_valid = 1'b1; req_aluop = 2'b10; req_funct = 6'h22; req_a = 32'd1; req_b = 32'd2;
        tick();
        req_valid = 1'b0;
        tick();
        chk_b("sub_ovf_valid", rsp_valid, 1'b1);
        chk_b("sub_ovf_carry", rsp_carry, 1'b0);
`ifdef ALU_CTRL_TRAP_EN
        chk_b("sub_ovf_trap", rsp_trap, 1'b1);
        chk_w("sub_ovf_result", rsp_result, 32'd0);
`else
        chk_b("sub_ovf_trap", rsp_trap, 1'b0);
        chk_w("sub_ovf_result", rsp_result, 32'hFFFFFFFF);
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Unsigned sub 2 - 1 with injected overflow: never traps
        req_valid = 1'b1; req_funct = 6'h23; req_a = 32'd2; req_b = 32'd1;
        tick();
        req_valid = 1'b0;
        tick();
        chk_b("subu_trap", rsp_trap, 1'b0);
        chk_w("subu_result", rsp_result, 32'd1);
        chk_b("subu_carry", rsp_carry, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        force_ovf = 1'b0;

        // Illegal funct: response one edge after accept
        req_valid = 1'b1; req_aluop = 2'b10; req_funct = 6'h3F; req_a = 32'd9; req_b = 32'd9;
        tick();
        req_valid = 1'b0;
        chk_b("ill_valid", rsp_valid, 1'b1);
        chk_b("ill_flag", rsp_illegal, 1'b1);
        chk_w("ill_result", rsp_result, 32'd0);
        chk_b("ill_carry", rsp_carry, 1'b0);
        chk_b("ill_zero", rsp_zero, 1'b0);
        chk_b("ill_req_ready", req_ready, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_b("ill_retired", rsp_valid, 1'b0);

        // Reserved ALUOp
        req_valid = 1'b1; req_aluop = 2'b11; req_funct = 6'h20;
        tick();
        req_valid = 1'b0;
        chk_b("rsvd_valid", rsp_valid, 1'b1);
        chk_b("rsvd_illegal", rsp_illegal, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset pulse while in EXEC
        req_valid = 1'b1; req_aluop = 2'b00; req_a = 32'd3; req_b = 32'd4;
        tick();
        req_valid = 1'b0;
        chk_w("exec_alu_a", alu_a, 32'd3);
        rst_n = 1'b0;
        #1;
        chk_w("midrst_alu_a", alu_a, 32'd0);
        chk_w("midrst_alu_b", alu_b, 32'd0);
        chk_op("midrst_alu_op", alu_operation, 4'b0000);
        chk_b("midrst_rsp_valid", rsp_valid, 1'b0);
        chk_b("midrst_illegal", rsp_illegal, 1'b0);
        chk_b("midrst_req_ready", req_ready, 1'b1);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        chk_b("postrst_rsp_valid", rsp_valid, 1'b0);
        chk_b("postrst_req_ready", req_ready, 1'b1);

        // Back-to-back logical ops with the consumer always ready
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_aluop = 2'b10; req_a = 32'hF0F000FF; req_b = 32'h0FF00F0F;
        for (int i = 0; i < 4; i++) begin
            req_funct = b2b_funct[i];
            tick();
            chk_op("b2b_op", alu_operation, b2b_op[i]);
            chk_b("b2b_busy", req_ready, 1'b0);
            tick();
            chk_b("b2b_valid", rsp_valid, 1'b1);
            chk_w("b2b_result", rsp_result, b2b_res[i]);
            chk_b("b2b_illegal", rsp_illegal, 1'b0);
            tick();
            chk_b("b2b_retired", rsp_valid, 1'b0);
            chk_b("b2b_ready", req_ready, 1'b1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
